// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains a first-word-fall-through FIFO one byte per pop and
// packs the bytes LSB-first into LANES-byte words. A flush request emits a
// partial word with a lane mask.
module fifo_word_packer #(
  parameter int DSIZE = 8,
  parameter int LANES = 4
) (
  input  logic                   rclk,
  input  logic                   rrst_n,
  input  logic                   rempty,
  input  logic [DSIZE-1:0]       rdata,
  output logic                   rinc,
  input  logic                   flush,
  output logic [DSIZE*LANES-1:0] out_data,
  output logic [LANES-1:0]       out_keep,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int CW = $clog2(LANES);
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  typedef enum logic {FILL, FLUSH} state_t;

  state_t                      state;
  logic [CW-1:0]               cnt;
  logic [LANES-1:0][DSIZE-1:0] acc;
  logic [LANES-1:0][DSIZE-1:0] full_word;
  logic [LANES-1:0][DSIZE-1:0] part_word;
  logic [LANES-1:0]            part_keep;
  logic                        out_free;

  // The output register can take a new word when it is empty or being accepted.
  assign out_free = ~out_valid | out_ready;

  // A pop is only safe in FILL with data present, no flush pending, and room
  // for the word that the last lane would complete.
  assign rinc = rrst_n & ~rempty & ~flush & (state == FILL) &
                ((cnt != LAST) | out_free);

  assign busy = (cnt != '0) | out_valid;

  // Build the complete word (head byte in the top lane) and the masked partial word.
  always_comb begin
    full_word       = acc;
    full_word[LAST] = rdata;
    part_word       = '0;
    part_keep       = '0;
    for (int i = 0; i < LANES; i++) begin
      if (CW'(i) < cnt) begin
        part_word[i] = acc[i];
        part_keep[i] = 1'b1;
      end
    end
  end

  // Accumulate popped bytes, load finished or flushed words, and run the FILL/FLUSH FSM.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state     <= FILL;
      cnt       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        FILL: begin
          if (rinc) begin
            acc[cnt] <= rdata;
            if (cnt == LAST) begin
              out_data  <= full_word;
              out_keep  <= '1;
              out_valid <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (flush && (cnt != '0)) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (out_free) begin
            out_data  <= part_word;
            out_keep  <= part_keep;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer: drives fifo_word_packer from a queue-based FIFO model and
// checks every accepted word against the byte stream actually popped.
module tb_fifo_word_packer;

  logic        rclk = 1'b0;
  logic        rrst_n;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic        flush;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  fifo_word_packer #(.DSIZE(8), .LANES(4)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .flush     (flush),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // Free-running read clock.
  always #5 rclk = ~rclk;

  typedef struct {
    logic        push;
    logic [7:0]  din;
    logic        fl;
    logic        rdy;
    logic        eRinc;
    logic        eValid;
    logic [31:0] eData;
    logic [3:0]  eKeep;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  fifoQ[$];
  logic [7:0]  pending[$];
  int          total = 0;
  int          bad = 0;
  int          wordCount = 0;
  int          outBytes = 0;
  logic        sRinc, sValid;
  logic [31:0] sData;
  logic [3:0]  sKeep;
  logic        prevHeld = 1'b0;
  logic [31:0] prevData;
  logic [3:0]  prevKeep;
  logic [31:0] lastWord;
  logic [3:0]  lastKeep;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic addVec(input logic push, input logic [7:0] din, input logic fl, input logic rdy,
                        input logic eRinc, input logic eValid, input logic [31:0] eData,
                        input logic [3:0] eKeep);
    vec_t v;
    v.push = push; v.din = din; v.fl = fl; v.rdy = rdy;
    v.eRinc = eRinc; v.eValid = eValid; v.eData = eData; v.eKeep = eKeep;
    vecs.push_back(v);
  endtask

  task automatic acceptWord(input logic [31:0] data, input logic [3:0] keep);
    int          n;
    logic        underflow;
    logic [31:0] expWord;
    n = $countones(keep);
    underflow = 1'b0;
    expWord = '0;
    checkOutput("keepNonZero", 64'(n != 0), 64'd1);
    checkOutput("keepShape", 64'(keep), 64'((1 << n) - 1));
    for (int i = 0; i < n; i++) begin
      if (pending.size() != 0) expWord[i*8 +: 8] = pending.pop_front();
      else underflow = 1'b1;
    end
    checkOutput("noExtraBytes", 64'(underflow), 64'd0);
    checkOutput("wordData", 64'(data), 64'(expWord));
    wordCount++;
    outBytes += n;
    lastWord = data;
    lastKeep = keep;
  endtask

  // One clock: drive at the negedge, sample 1 time unit later, update the models at the posedge.
  task automatic applyStimulus(input logic fl, input logic rdy, input logic stall);
    rempty = stall || (fifoQ.size() == 0);
    rdata = (fifoQ.size() != 0) ? fifoQ[0] : 8'h00;
    flush = fl;
    out_ready = rdy;
    #1;
    sRinc = rinc; sValid = out_valid; sData = out_data; sKeep = out_keep;
    checkOutput("rincWhileEmpty", 64'(sRinc && rempty), 64'd0);
    if (prevHeld) begin
      checkOutput("holdValid", 64'(sValid), 64'd1);
      checkOutput("holdData", 64'(sData), 64'(prevData));
      checkOutput("holdKeep", 64'(sKeep), 64'(prevKeep));
    end
    prevHeld = sValid && !rdy;
    prevData = sData;
    prevKeep = sKeep;
    @(posedge rclk);
    if (sRinc && fifoQ.size() != 0) pending.push_back(fifoQ.pop_front());
    if (sValid && rdy) acceptWord(sData, sKeep);
    @(negedge rclk);
  endtask

  // Abort guard in case the design stops responding.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    int pushed;
    int wc0;

    // {push, byte, flush, ready, exp rinc, exp valid, exp data, exp keep}
    addVec(1, 8'h11, 0, 1, 1, 0, 32'h0, 4'h0);
    addVec(1, 8'h22, 0, 1, 1, 0, 32'h0, 4'h0);
    addVec(1, 8'h33, 0, 1, 1, 0, 32'h0, 4'h0);
    addVec(1, 8'h44, 0, 1, 1, 0, 32'h0, 4'h0);
    addVec(0, 8'h00, 0, 1, 0, 1, 32'h44332211, 4'hF);
    addVec(0, 8'h00, 0, 1, 0, 0, 32'h0, 4'h0);
    addVec(1, 8'hAA, 0, 1, 1, 0, 32'h0, 4'h0);
    addVec(1, 8'hBB, 0, 1, 1, 0, 32'h0, 4'h0);
    addVec(0, 8'h00, 1, 1, 0, 0, 32'h0, 4'h0);
    addVec(0, 8'h00, 0, 1, 0, 0, 32'h0, 4'h0);
    addVec(0, 8'h00, 0, 1, 0, 1, 32'h0000BBAA, 4'h3);
    addVec(0, 8'h00, 1, 1, 0, 0, 32'h0, 4'h0);
    addVec(0, 8'h00, 0, 1, 0, 0, 32'h0, 4'h0);
    addVec(1, 8'h01, 0, 1, 1, 0, 32'h0, 4'h0);
    addVec(1, 8'hCC, 1, 1, 0, 0, 32'h0, 4'h0);
    addVec(0, 8'h00, 0, 1, 0, 0, 32'h0, 4'h0);
    addVec(0, 8'h00, 0, 1, 1, 1, 32'h00000001, 4'h1);
    addVec(1, 8'hDD, 0, 1, 1, 0, 32'h0, 4'h0);
    addVec(1, 8'hEE, 0, 1, 1, 0, 32'h0, 4'h0);
    addVec(1, 8'hFF, 0, 1, 1, 0, 32'h0, 4'h0);
    addVec(0, 8'h00, 0, 1, 0, 1, 32'hFFEEDDCC, 4'hF);

    rrst_n = 1'b0;
    rempty = 1'b0;
    rdata = 8'h5A;
    flush = 1'b0;
    out_ready = 1'b0;
    @(negedge rclk);
    checkOutput("rstValid", 64'(out_valid), 64'd0);
    checkOutput("rstData", 64'(out_data), 64'd0);
    checkOutput("rstKeep", 64'(out_keep), 64'd0);
    checkOutput("rstRinc", 64'(rinc), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    rrst_n = 1'b1;

    $display("[TB] table vectors");
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].push) fifoQ.push_back(vecs[i].din);
      applyStimulus(vecs[i].fl, vecs[i].rdy, 1'b0);
      checkOutput($sformatf("v%0d_rinc", i), 64'(sRinc), 64'(vecs[i].eRinc));
      checkOutput($sformatf("v%0d_valid", i), 64'(sValid), 64'(vecs[i].eValid));
      if (vecs[i].eValid) begin
        checkOutput($sformatf("v%0d_data", i), 64'(sData), 64'(vecs[i].eData));
        checkOutput($sformatf("v%0d_keep", i), 64'(sKeep), 64'(vecs[i].eKeep));
      end
    end

    $display("[TB] backpressure sequence");
    for (int b = 1; b <= 8; b++) fifoQ.push_back(8'(b));
    for (int k = 0; k < 12; k++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bpRincStalled", 64'(sRinc), 64'd0);
    checkOutput("bpHeldValid", 64'(sValid), 64'd1);
    checkOutput("bpHeldData", 64'(sData), 64'h04030201);
    checkOutput("bpFifoLeft", 64'(fifoQ.size()), 64'd1);
    checkOutput("bpFifoHead", 64'(fifoQ[0]), 64'h08);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("bpResumeRinc", 64'(sRinc), 64'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("bpSecondValid", 64'(sValid), 64'd1);
    checkOutput("bpSecondData", 64'(sData), 64'h08070605);

    $display("[TB] async reset sequence");
    for (int b = 0; b < 4; b++) fifoQ.push_back(8'hA1 + 8'(b));
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 1'b0);
    fifoQ.push_back(8'hB1);
    fifoQ.push_back(8'hB2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    fifoQ.push_back(8'hC1);
    rempty = 1'b0;
    rdata = 8'hC1;
    #1;
    checkOutput("preRstValid", 64'(out_valid), 64'd1);
    checkOutput("preRstBusy", 64'(busy), 64'd1);
    #1;
    rrst_n = 1'b0;
    #1;
    checkOutput("arstValid", 64'(out_valid), 64'd0);
    checkOutput("arstData", 64'(out_data), 64'd0);
    checkOutput("arstKeep", 64'(out_keep), 64'd0);
    checkOutput("arstRinc", 64'(rinc), 64'd0);
    checkOutput("arstBusy", 64'(busy), 64'd0);
    pending.delete();
    prevHeld = 1'b0;
    @(negedge rclk);
    rrst_n = 1'b1;
    fifoQ.push_back(8'hC2);
    fifoQ.push_back(8'hC3);
    fifoQ.push_back(8'hC4);
    wc0 = wordCount;
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("postRstWords", 64'(wordCount), 64'(wc0 + 1));
    checkOutput("postRstData", 64'(lastWord), 64'hC4C3C2C1);
    checkOutput("postRstKeep", 64'(lastKeep), 64'hF);

    $display("[TB] random stream");
    outBytes = 0;
    pushed = 0;
    for (int k = 0; k < 20000 && pushed < 1000; k++) begin
      if ($urandom_range(0, 2) != 0) begin
        fifoQ.push_back(8'($urandom));
        pushed++;
      end
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0);
    end
    for (int k = 0; k < 4000; k++) begin
      if (fifoQ.size() == 0 && !busy) break;
      applyStimulus(fifoQ.size() == 0, 1'b1, 1'b0);
    end
    checkOutput("rndAllPushed", 64'(pushed), 64'd1000);
    checkOutput("rndFifoDrained", 64'(fifoQ.size()), 64'd0);
    checkOutput("rndNothingPending", 64'(pending.size()), 64'd0);
    checkOutput("rndOutBytes", 64'(outBytes), 64'd1000);
    checkOutput("rndIdle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
